// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8:1 data mux: steps select over every channel, packs the nibbles
// into one frame and hands it off with valid/ready. Define MUX_SCAN_CONT_EN for continuous scanning.
module mux8_scan_ctrl #(
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 3,
    parameter int FRAME_W = DATA_W * (2 ** SEL_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  mux_out,
    output logic [SEL_W-1:0]   select,
    output logic               busy,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [7:0]         frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = '1;

    state_t state;
    state_t state_nx;
    logic   accept;

    assign accept = (state == HOLD) && frame_ready;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: the next state defaults to the current one before the case, so no
    // path leaves state_nx unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = SCAN;
            SCAN: if (select == LAST_SEL) state_nx = HOLD;
            HOLD: begin
                if (frame_ready) begin
`ifdef MUX_SCAN_CONT_EN
                    state_nx = SCAN;
`else
                    state_nx = IDLE;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        frame_valid = 1'b0;
        case (state)
            SCAN: busy = 1'b1;
            HOLD: begin
                busy        = 1'b1;
                frame_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // The mux is combinational, so mux_out already reflects the select presented this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            select <= '0;
        end else if (state == SCAN && select != LAST_SEL) begin
            select <= select + 1'b1;
        end else begin
            select <= '0;
        end
    end

    // NOTE: the frame store is reset because an aborted scan must leave no partial data behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
        end else if (state == SCAN) begin
            frame[select*DATA_W +: DATA_W] <= mux_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (accept) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Self-checking bench for mux8_scan_ctrl: a behavioural mux feeds the DUT, and expected
// frames are queued at start and compared at the accepting handshake.
module tb_mux8_scan_ctrl;

    localparam int DATA_W  = 4;
    localparam int SEL_W   = 3;
    localparam int FRAME_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [DATA_W-1:0]  mux_out;
    logic [SEL_W-1:0]   select;
    logic               busy;
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               frame_ready;
    logic [7:0]         frame_cnt;

    logic [DATA_W-1:0]  ch_data [8];
    logic [FRAME_W-1:0] exp_q [$];
    logic [7:0]         exp_cnt;
    int                 n_tests = 0;
    int                 n_fail  = 0;

    always #5 clk = ~clk;

    always_comb mux_out = ch_data[select];

    mux8_scan_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W), .FRAME_W(FRAME_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mux_out    (mux_out),
        .select     (select),
        .busy       (busy),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Fill the mux channels (pattern 0: channel n returns n+1) and queue the frame they should produce.
    task automatic load_channels(input int pattern);
        logic [FRAME_W-1:0] exp_frame;
        for (int i = 0; i < 8; i++) begin
            ch_data[i] = (pattern == 0) ? 4'(i + 1) : 4'($urandom_range(0, 15));
            exp_frame[4*i +: 4] = ch_data[i];
        end
        exp_q.push_back(exp_frame);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_sel"},   32'(select), 32'd0);
    endtask

    task automatic pop_compare(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, frame, exp_q.pop_front());
        end
    endtask

    // Full single-shot transaction; stall > 0 holds frame_ready low in HOLD and pokes start meanwhile.
    task automatic scan_frame(input int stall);
        logic [FRAME_W-1:0] held;
        frame_ready = (stall == 0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            check("scan_sel",   32'(select), 32'(i));
            check("scan_busy",  32'(busy), 32'd1);
            check("scan_valid", 32'(frame_valid), 32'd0);
            @(negedge clk);
        end
        check("hold_valid", 32'(frame_valid), 32'd1);
        check("hold_sel",   32'(select), 32'd0);
        held = frame;
        for (int s = 0; s < stall; s++) begin
            start = (s == 2);
            @(negedge clk);
            check("stall_valid", 32'(frame_valid), 32'd1);
            check("stall_frame", frame, held);
            check("stall_cnt",   32'(frame_cnt), 32'(exp_cnt));
        end
        frame_ready = 1'b1;
        start = (stall > 0);
        pop_compare("accept_frame");
        exp_cnt++;
        @(negedge clk);
        start = 1'b0;
        frame_ready = 1'b0;
        check_idle("after_accept");
        check("after_accept_cnt", 32'(frame_cnt), 32'(exp_cnt));
        if (stall > 0) begin
            @(negedge clk);
            check("start_at_accept_ignored", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        frame_ready = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 8; i++) ch_data[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_frame", frame, 32'd0);
        check("reset_cnt",   32'(frame_cnt), 32'd0);

`ifdef MUX_SCAN_CONT_EN
        // Continuous mode: one start yields a frame every 9 cycles and busy never drops.
        frame_ready = 1'b1;
        load_channels(1);
        for (int k = 1; k < 3; k++) exp_q.push_back(exp_q[0]);
        pulse_start();
        for (int c = 1; c <= 27; c++) begin
            check("cont_busy",  32'(busy), 32'd1);
            check("cont_valid", 32'(frame_valid), 32'((c % 9) == 0));
            if (frame_valid && frame_ready) begin
                pop_compare("cont_frame");
                exp_cnt++;
            end
            @(negedge clk);
        end
        check("cont_cnt", 32'(frame_cnt), 32'(exp_cnt));
`else
        // Reset in the 4th scan cycle (select = 3), before any frame has been accepted.
        load_channels(0);
        pulse_start();
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("pre_abort_sel", 32'(select), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_front());
        check_idle("abort");
        check("abort_frame", frame, 32'd0);
        check("abort_cnt",   32'(frame_cnt), 32'(exp_cnt));

        // Basic scan, expected frame 32'h87654321.
        load_channels(0);
        check("model_frame", exp_q[0], 32'h8765_4321);
        scan_frame(0);

        // No second frame without a second start.
        repeat (15) @(negedge clk);
        check_idle("single_shot");
        check("single_shot_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Backpressure for 20 cycles with start poked during HOLD and at the accepting edge.
        load_channels(1);
        scan_frame(20);

        // A few random frames, then a fresh reset and 256 accepts to wrap the counter.
        for (int k = 0; k < 3; k++) begin
            load_channels(1);
            scan_frame(k);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        check("wrap_start_cnt", 32'(frame_cnt), 32'd0);
        for (int k = 0; k < 256; k++) begin
            load_channels(1);
            scan_frame(0);
        end
        check("wrap_cnt", 32'(frame_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
